if_id_ctrl: RTL and testbench

Consumer-side partner of the instruction-fetch stage in the 5-stage MIPS pipeline. It holds the IF/ID pipeline register, resolves BEQ/BNE in ID, and generates the `brTaken`, `brOffset` and `Haz_Det` signals that steer the fetch-stage PC. It also detects load-use and branch-operand hazards, stalls fetch, and flushes the wrong-path instruction on a taken branch.

---
 rtl/if_id_ctrl.sv | 119 +++++++++++
 tb/tb_if_id_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/if_id_ctrl.sv
// if_id_ctrl: IF/ID pipeline register with ID-stage branch resolution and
// hazard detection for a 5-stage MIPS pipeline. Drives brTaken/brOffset/Haz_Det
// back to the fetch stage.
// Optional feature macro: IFID_PERF_CNT_EN adds stall_cnt / flush_cnt counters.
module if_id_ctrl #(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instr,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        ex_mem_read,
    input  logic        ex_reg_write,
    input  logic [4:0]  ex_dest,
    input  logic        mem_mem_read,
    input  logic [4:0]  mem_dest,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic        id_valid,
    output logic        brTaken,
    output logic [31:0] brOffset,
    output logic        Haz_Det,
    output logic        id_flush
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    state_t     state;
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       is_beq;
    logic       is_bne;
    logic       is_branch;
    logic       uses_rt;
    logic       load_use;
    logic       br_haz;
    logic       cond;

    // Decode the ID instruction and evaluate hazards / branch condition.
    // Register 0 is never a real producer, so a zero destination is ignored.
    always_comb begin
        opcode    = id_instr[31:26];
        rs        = id_instr[25:21];
        rt        = id_instr[20:16];
        is_beq    = (opcode == OP_BEQ);
        is_bne    = (opcode == OP_BNE);
        is_branch = is_beq | is_bne;
        uses_rt   = (opcode == OP_RTYPE) | is_branch | (opcode == OP_SW);

        load_use  = id_valid & ex_mem_read & (ex_dest != 5'd0) &
                    ((ex_dest == rs) | (uses_rt & (ex_dest == rt)));

        // Branch compares in ID, so any in-flight producer of its operands
        // that the forwarding network cannot yet reach forces a wait.
        br_haz    = is_branch &
                    ((ex_reg_write & (ex_dest != 5'd0) &
                      ((ex_dest == rs) | (ex_dest == rt))) |
                     (mem_mem_read & (mem_dest != 5'd0) &
                      ((mem_dest == rs) | (mem_dest == rt))));

        cond      = is_beq ? (rs_val == rt_val) : (rs_val != rt_val);
    end

    assign Haz_Det  = load_use | br_haz;
    // A stall always wins over a taken branch: operands are not yet valid.
    assign brTaken  = id_valid & is_branch & cond & ~Haz_Det;
    assign brOffset = {{16{id_instr[15]}}, id_instr[15:0]};
    assign id_flush = (state == FLUSH);

    // IF/ID register and RUN/STALL/FLUSH state: hold on stall, bubble on a
    // taken branch (wrong-path fetch discarded), otherwise advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            id_pc    <= RESET_PC;
            id_instr <= 32'd0;
            id_valid <= 1'b0;
        end else if (Haz_Det) begin
            state    <= STALL;
        end else if (brTaken) begin
            state    <= FLUSH;
            id_pc    <= if_pc;
            id_instr <= 32'd0;
            id_valid <= 1'b0;
        end else begin
            state    <= RUN;
            id_pc    <= if_pc;
            id_instr <= if_instr;
            id_valid <= 1'b1;
        end
    end

`ifdef IFID_PERF_CNT_EN
    // Event counters for stall and flush cycles; wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (Haz_Det) stall_cnt <= stall_cnt + 32'd1;
            if (brTaken) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_id_ctrl.sv
// Testbench for if_id_ctrl: directed per-cycle vectors; each vector pushes its
// hand-computed expected outputs into a scoreboard queue, and a monitor on the
// falling edge pops and compares.
module tb_if_id_ctrl;

    localparam logic [31:0] RP = 32'hBFC0_0000;

    localparam logic [31:0] IA   = 32'h2001_0001; // addi $1,$0,1
    localparam logic [31:0] IB   = 32'h2002_0002; // addi $2,$0,2
    localparam logic [31:0] IC   = 32'h2007_0007; // addi $7,$0,7
    localparam logic [31:0] IX   = 32'h2008_0008;
    localparam logic [31:0] IY   = 32'h2009_0009;
    localparam logic [31:0] ADD  = 32'h00A6_1820; // add $3,$5,$6
    localparam logic [31:0] BEQ1 = 32'h1022_FFFE; // beq $1,$2,-2
    localparam logic [31:0] BNE1 = 32'h1422_0003; // bne $1,$2,+3
    localparam logic [31:0] BQ4  = 32'h1087_0010; // beq $4,$7,+16

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] if_pc = 32'd0, if_instr = 32'd0, rs_val = 32'd0, rt_val = 32'd0;
    logic        ex_mem_read = 1'b0, ex_reg_write = 1'b0, mem_mem_read = 1'b0;
    logic [4:0]  ex_dest = 5'd0, mem_dest = 5'd0;
    logic [31:0] id_pc, id_instr, brOffset;
    logic        id_valid, brTaken, Haz_Det, id_flush;
`ifdef IFID_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    if_id_ctrl #(.RESET_PC(RP)) dut (
        .clk(clk), .reset(reset), .if_pc(if_pc), .if_instr(if_instr),
        .rs_val(rs_val), .rt_val(rt_val), .ex_mem_read(ex_mem_read),
        .ex_reg_write(ex_reg_write), .ex_dest(ex_dest),
        .mem_mem_read(mem_mem_read), .mem_dest(mem_dest),
        .id_pc(id_pc), .id_instr(id_instr), .id_valid(id_valid),
        .brTaken(brTaken), .brOffset(brOffset), .Haz_Det(Haz_Det),
        .id_flush(id_flush)
`ifdef IFID_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic        chk;
        logic [31:0] pc, ins, off, sc, fc;
        logic        vld, fl, haz, br;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   vidx     = 0;

    task automatic cmp(input int idx, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL v%0d %s: got %h expected %h", idx, name, act, exp);
        end
    endtask

    // Apply one cycle of inputs just after the rising edge and queue the
    // outputs expected for that cycle.
    task automatic v(input logic rst, input logic [31:0] pc, input logic [31:0] ins,
                     input logic [31:0] rsv, input logic [31:0] rtv,
                     input logic exmr, input logic exrw, input logic [4:0] exd,
                     input logic mmr, input logic [4:0] md, input logic chk,
                     input logic [31:0] e_pc, input logic [31:0] e_ins,
                     input logic e_vld, input logic e_fl, input logic e_haz,
                     input logic e_br, input logic [31:0] e_off,
                     input logic [31:0] e_sc, input logic [31:0] e_fc);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; if_pc = pc; if_instr = ins; rs_val = rsv; rt_val = rtv;
        ex_mem_read = exmr; ex_reg_write = exrw; ex_dest = exd;
        mem_mem_read = mmr; mem_dest = md;
        e.idx = vidx; e.chk = chk; e.pc = e_pc; e.ins = e_ins; e.vld = e_vld;
        e.fl = e_fl; e.haz = e_haz; e.br = e_br; e.off = e_off; e.sc = e_sc; e.fc = e_fc;
        sb.push_back(e);
        vidx++;
    endtask

    // Monitor: compare DUT outputs against the queued expectation each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk) begin
                    cmp(e.idx, "id_pc",    id_pc,            e.pc);
                    cmp(e.idx, "id_instr", id_instr,         e.ins);
                    cmp(e.idx, "id_valid", {31'd0, id_valid}, {31'd0, e.vld});
                    cmp(e.idx, "id_flush", {31'd0, id_flush}, {31'd0, e.fl});
                    cmp(e.idx, "Haz_Det",  {31'd0, Haz_Det},  {31'd0, e.haz});
                    cmp(e.idx, "brTaken",  {31'd0, brTaken},  {31'd0, e.br});
                    cmp(e.idx, "brOffset", brOffset,         e.off);
`ifdef IFID_PERF_CNT_EN
                    cmp(e.idx, "stall_cnt", stall_cnt, e.sc);
                    cmp(e.idx, "flush_cnt", flush_cnt, e.fc);
`endif
                end
            end
        end
    end

    initial begin
        //   rst pc        instr rs  rt  exmr exrw exd mmr md  chk  e_pc      e_ins e_v e_f e_h e_b e_off         sc fc
        v(1, 32'h00, IA,   0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0);
        v(1, 32'h00, IA,   0, 0, 0, 0, 5'd0, 0, 5'd0, 1, RP,    32'h0, 0, 0, 0, 0, 32'h0, 0, 0);
        v(0, 32'h00, IA,   0, 0, 0, 0, 5'd0, 0, 5'd0, 1, RP,    32'h0, 0, 0, 0, 0, 32'h0, 0, 0);
        // free run
        v(0, 32'h04, IB,   0, 0, 0, 0, 5'd0, 0, 5'd0, 1, 32'h00, IA,  1, 0, 0, 0, 32'h1, 0, 0);
        v(0, 32'h08, ADD,  0, 0, 0, 0, 5'd0, 0, 5'd0, 1, 32'h04, IB,  1, 0, 0, 0, 32'h2, 0, 0);
        // load-use on $5, then ex_dest=0 gives no stall
        v(0, 32'h0C, IC,   0, 0, 1, 0, 5'd5, 0, 5'd0, 1, 32'h08, ADD, 1, 0, 1, 0, 32'h1820, 0, 0);
        v(0, 32'h0C, IC,   0, 0, 1, 0, 5'd0, 0, 5'd0, 1, 32'h08, ADD, 1, 0, 0, 0, 32'h1820, 1, 0);
        // addi does not read rt: load to $7 is no hazard
        v(0, 32'h10, BEQ1, 0, 0, 1, 0, 5'd7, 0, 5'd0, 1, 32'h0C, IC,  1, 0, 0, 0, 32'h7, 1, 0);
        // BEQ taken, offset -2
        v(0, 32'h14, IX,   7, 7, 0, 0, 5'd0, 0, 5'd0, 1, 32'h10, BEQ1, 1, 0, 0, 1, 32'hFFFF_FFFE, 1, 0);
        v(0, 32'h0C, IC,   0, 0, 0, 0, 5'd0, 0, 5'd0, 1, 32'h14, 32'h0, 0, 1, 0, 0, 32'h0, 1, 1);
        v(0, 32'h10, BNE1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 1, 32'h0C, IC,  1, 0, 0, 0, 32'h7, 1, 1);
        // BNE with equal operands: not taken
        v(0, 32'h14, BQ4,  5, 5, 0, 0, 5'd0, 0, 5'd0, 1, 32'h10, BNE1, 1, 0, 0, 0, 32'h3, 1, 1);
        // branch after load on $4: EX then MEM stall, then taken
        v(0, 32'h18, IY,   9, 9, 1, 1, 5'd4, 0, 5'd0, 1, 32'h14, BQ4, 1, 0, 1, 0, 32'h10, 1, 1);
        v(0, 32'h18, IY,   9, 9, 0, 0, 5'd0, 1, 5'd4, 1, 32'h14, BQ4, 1, 0, 1, 0, 32'h10, 2, 1);
        v(0, 32'h18, IY,   9, 9, 0, 0, 5'd0, 0, 5'd0, 1, 32'h14, BQ4, 1, 0, 0, 1, 32'h10, 3, 1);
        v(0, 32'h58, IA,   0, 0, 0, 0, 5'd0, 0, 5'd0, 1, 32'h18, 32'h0, 0, 1, 0, 0, 32'h0, 3, 2);
        v(0, 32'h5C, BNE1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 1, 32'h58, IA,  1, 0, 0, 0, 32'h1, 3, 2);
        // ALU result on $2 feeding BNE: one stall, then taken
        v(0, 32'h60, IB,   1, 2, 0, 1, 5'd2, 0, 5'd0, 1, 32'h5C, BNE1, 1, 0, 1, 0, 32'h3, 3, 2);
        v(0, 32'h60, IB,   1, 2, 0, 0, 5'd0, 0, 5'd0, 1, 32'h5C, BNE1, 1, 0, 0, 1, 32'h3, 4, 2);
        // reset during flush
        v(1, 32'h6C, IC,   0, 0, 0, 0, 5'd0, 0, 5'd0, 1, 32'h60, 32'h0, 0, 1, 0, 0, 32'h0, 4, 3);
        v(0, 32'h6C, IC,   0, 0, 0, 0, 5'd0, 0, 5'd0, 1, RP,    32'h0, 0, 0, 0, 0, 32'h0, 0, 0);
        v(0, 32'h70, ADD,  0, 0, 0, 0, 5'd0, 0, 5'd0, 1, 32'h6C, IC,  1, 0, 0, 0, 32'h7, 0, 0);
        // reset during stall (load-use on rt $6)
        v(1, 32'h74, IA,   0, 0, 1, 0, 5'd6, 0, 5'd0, 1, 32'h70, ADD, 1, 0, 1, 0, 32'h1820, 0, 0);
        v(0, 32'h74, IA,   0, 0, 1, 0, 5'd6, 0, 5'd0, 1, RP,    32'h0, 0, 0, 0, 0, 32'h0, 0, 0);

        @(negedge clk);
        @(negedge clk);
        cmp(-1, "scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
